sm_warp_alloc: RTL and testbench
================================

// Module: sm_warp_alloc
// PURPOSE
//  Parametrised warp-slot allocator for an SM core. It accepts a multi-warp block request from the TPC.
//  It waits until enough warp slots are free, then issues one warp id per cycle to the warp launcher.
//  Warp completions are buffered in a response FIFO and forwarded to the TPC.
//  A completed slot is freed as soon as its completion is accepted.
//  Sits between the TPC request/response channels and the SM warp scheduler.
// PARAMETERS
//  NUM_WARP        8                    warp slots in the SM (>=2)
//  WID_W           $clog2(NUM_WARP)     width of a warp id
//  MAX_BLK_WARPS   4                    max warps per request (1..NUM_WARP)
//  CNT_W           $clog2(MAX_BLK_WARPS+1)  width of the warp-count field
//  RSP_DEPTH       4                    completion FIFO entries (power of 2, >=2)
// PORTS
//  clk                  in   1      clock
//  rst_n                in   1      asynchronous reset, active low
//  tpc_req_valid_i      in   1      block request valid
//  tpc_req_ready_o      out  1      allocator can accept a request
//  tpc_req_nwarp_i      in   CNT_W  warps requested
//  tpc_rsp_valid_o      out  1      completion available to TPC
//  tpc_rsp_ready_i      in   1      TPC accepts the completion
//  tpc_rsp_wid_o        out  WID_W  completed warp id
//  sm_warp_req_valid_o  out  1      warp launch valid
//  sm_warp_req_ready_i  in   1      launcher accepts the warp
//  sm_warp_req_wid_o    out  WID_W  warp id to launch
//  sm_warp_req_last_o   out  1      last warp of the current block
//  sm_warp_rsp_valid_i  in   1      warp completed
//  sm_warp_rsp_ready_o  out  1      completion can be accepted
//  sm_warp_rsp_wid_i    in   WID_W  completed warp id
//  free_cnt_o           out  WID_W+1  registered count of free slots
//  err_o                out  1      1-cycle pulse: completion of an unassigned wid
// BEHAVIOUR
//  Handshakes
//  - Fire = valid & ready.
//  - Valid never depends on ready.
//  - While valid=1 and ready=0, the held data must stay stable.
//  Reset (asynchronous)
//  - bitmap=0, free_cnt=NUM_WARP, rr_ptr=0, FIFO empty, state=IDLE.
//  - Output values in reset: tpc_req_ready_o=1, sm_warp_rsp_ready_o=1, all other outputs 0.
//  - Reset mid-allocation discards the pending block; no warps are re-issued.
//  FSM states
//  - IDLE:
//    - tpc_req_ready_o=1.
//    - On fire, latch rem = min(nwarp, MAX_BLK_WARPS).
//    - nwarp==0 is consumed with no warps issued; stay in IDLE.
//    - Otherwise go to WAIT.
//  - WAIT:
//    - tpc_req_ready_o=0.
//    - When free_cnt_o >= rem, go to ALLOC.
//    - All-or-nothing: no partial issue.
//  - ALLOC:
//    - sm_warp_req_valid_o=1.
//    - wid = first free slot at or after rr_ptr, wrapping past NUM_WARP-1.
//    - wid is registered on entry to ALLOC and after each fire, so it is stable while stalled.
//    - last_o = (rem==1).
//    - On fire: set bitmap[wid], rr_ptr = (wid+1) mod NUM_WARP, rem--.
//    - When rem reaches 0, go to IDLE.
//  Completions
//  - sm_warp_rsp_ready_o = !fifo_full.
//  - On fire with bitmap[wid]=1: clear the bit and push wid.
//  - The freed slot is visible to free_cnt_o and the allocator in the next cycle.
//  - tpc_rsp_valid_o rises 1 cycle after the push; FIFO order is preserved.
//  - On fire with bitmap[wid]=0: consumed, not pushed, err_o pulses 1 cycle.
//  - Pop on TPC fire.
//  - Push and pop in the same cycle are both allowed when not full.
//  Simultaneous events
//  - Alloc fire and completion fire in the same cycle update bitmap and free_cnt together.
//  - free_cnt' = free_cnt - alloc + release.
//  - Freeing slot k in the same cycle the ALLOC search runs does not make k eligible until the next cycle.
// TESTING
//  - Reset, request nwarp=3 with launcher always ready:
//    -> wids 0,1,2 on consecutive cycles, last on wid 2, free_cnt=5, back to IDLE.
//  - NUM_WARP=8 all assigned; request nwarp=2:
//    -> stays in WAIT; complete wids 5,6 -> ALLOC issues 5 then 6.
//  - Launcher ready=0 for 3 cycles in ALLOC:
//    -> valid and wid held constant; a single fire sets only that bit.
//  - TPC ready=0; 5 completions with RSP_DEPTH=4:
//    -> 4 accepted, sm_warp_rsp_ready_o=0 on the 5th; draining returns wids in arrival order.
//  - Completion of an unassigned wid=7:
//    -> err_o pulses, no tpc_rsp, bitmap unchanged.
//  - Assert rst_n low mid-ALLOC after 1 of 4 warps issued:
//    -> all outputs at reset values, free_cnt=8.

Source files
------------

// File: rtl/sm_warp_alloc_if.sv
// Handshake bundle for the warp-slot allocator: TPC request/response
// channels plus the warp launch and warp completion channels.
interface sm_warp_alloc_if #(
    parameter int NUM_WARP      = 8,
    parameter int MAX_BLK_WARPS = 4,
    parameter int WID_W         = $clog2(NUM_WARP),
    parameter int CNT_W         = $clog2(MAX_BLK_WARPS + 1)
);
    logic             tpc_req_valid;
    logic             tpc_req_ready;
    logic [CNT_W-1:0] tpc_req_nwarp;

    logic             tpc_rsp_valid;
    logic             tpc_rsp_ready;
    logic [WID_W-1:0] tpc_rsp_wid;

    logic             sm_warp_req_valid;
    logic             sm_warp_req_ready;
    logic [WID_W-1:0] sm_warp_req_wid;
    logic             sm_warp_req_last;

    logic             sm_warp_rsp_valid;
    logic             sm_warp_rsp_ready;
    logic [WID_W-1:0] sm_warp_rsp_wid;

    // allocator side
    modport slave (
        input  tpc_req_valid,
        input  tpc_req_nwarp,
        output tpc_req_ready,
        output tpc_rsp_valid,
        output tpc_rsp_wid,
        input  tpc_rsp_ready,
        output sm_warp_req_valid,
        output sm_warp_req_wid,
        output sm_warp_req_last,
        input  sm_warp_req_ready,
        input  sm_warp_rsp_valid,
        input  sm_warp_rsp_wid,
        output sm_warp_rsp_ready
    );

    // TPC / launcher side
    modport master (
        output tpc_req_valid,
        output tpc_req_nwarp,
        input  tpc_req_ready,
        input  tpc_rsp_valid,
        input  tpc_rsp_wid,
        output tpc_rsp_ready,
        input  sm_warp_req_valid,
        input  sm_warp_req_wid,
        input  sm_warp_req_last,
        output sm_warp_req_ready,
        output sm_warp_rsp_valid,
        output sm_warp_rsp_wid,
        input  sm_warp_rsp_ready
    );
endinterface

// File: rtl/sm_warp_alloc.sv
// Warp-slot allocator: waits for enough free slots, issues one warp id per
// cycle round-robin, and forwards warp completions to the TPC via a FIFO.
module sm_warp_alloc #(
    parameter int NUM_WARP      = 8,
    parameter int WID_W         = $clog2(NUM_WARP),
    parameter int MAX_BLK_WARPS = 4,
    parameter int CNT_W         = $clog2(MAX_BLK_WARPS + 1),
    parameter int RSP_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    sm_warp_alloc_if.slave bus,
    output logic [WID_W:0] free_cnt,
    output logic           err
);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    localparam logic [WID_W-1:0] LAST_WID = WID_W'(NUM_WARP - 1);
    localparam logic [WID_W-1:0] WID_ONE  = WID_W'(1);
    localparam logic [WID_W:0]   FC_ONE   = (WID_W + 1)'(1);
    localparam logic [WID_W:0]   FC_RST   = (WID_W + 1)'(NUM_WARP);
    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_MAX  = CNT_W'(MAX_BLK_WARPS);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(RSP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ALLOC
    } state_t;

    state_t state, state_n;

    logic [NUM_WARP-1:0] bitmap, bitmap_n;
    logic [CNT_W-1:0]    rem;
    logic [CNT_W-1:0]    req_rem;
    logic [WID_W-1:0]    rr_ptr;
    logic [WID_W-1:0]    wid_q;
    logic [WID_W-1:0]    wid_after;
    logic                load_wid;

    logic [WID_W-1:0]    srch_start;
    logic [NUM_WARP-1:0] srch_map;
    logic [WID_W-1:0]    srch_wid;

    logic req_fire;
    logic alloc_fire;
    logic cpl_fire;
    logic cpl_hit;
    logic push;
    logic pop;

    logic [WID_W-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;

    assign req_fire   = bus.tpc_req_valid & bus.tpc_req_ready;
    assign alloc_fire = bus.sm_warp_req_valid & bus.sm_warp_req_ready;
    assign cpl_fire   = bus.sm_warp_rsp_valid & bus.sm_warp_rsp_ready;
    assign cpl_hit    = cpl_fire & bitmap[bus.sm_warp_rsp_wid];
    assign push       = cpl_hit;
    assign pop        = bus.tpc_rsp_valid & bus.tpc_rsp_ready;

    // Oversized requests are clamped to the per-block maximum.
    assign req_rem = (bus.tpc_req_nwarp > REM_MAX) ? REM_MAX
                                                   : bus.tpc_req_nwarp;

    assign wid_after = (wid_q == LAST_WID) ? '0 : wid_q + WID_ONE;

    assign bus.sm_warp_req_wid  = wid_q;
    assign bus.sm_warp_req_last = (state == S_ALLOC) && (rem == REM_ONE);

    assign bus.tpc_rsp_valid     = (fifo_cnt != '0);
    assign bus.tpc_rsp_wid       = mem[rd_ptr];
    assign bus.sm_warp_rsp_ready = (fifo_cnt != FIFO_FULL);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and handshake outputs of the allocation FSM.
    always_comb begin
        state_n               = state;
        bus.tpc_req_ready     = 1'b0;
        bus.sm_warp_req_valid = 1'b0;
        load_wid              = 1'b0;
        unique case (state)
            S_IDLE: begin
                bus.tpc_req_ready = 1'b1;
                if (bus.tpc_req_valid && (bus.tpc_req_nwarp != '0)) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (int'(free_cnt) >= int'(rem)) begin
                    state_n  = S_ALLOC;
                    load_wid = 1'b1;
                end
            end
            S_ALLOC: begin
                bus.sm_warp_req_valid = 1'b1;
                if (bus.sm_warp_req_ready) begin
                    if (rem == REM_ONE) begin
                        state_n = S_IDLE;
                    end else begin
                        load_wid = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Search inputs: after a fire the slot just issued is masked out and
    // the search resumes right after it; slots freed this cycle still
    // look busy because the search sees the current bitmap.
    always_comb begin
        srch_start = rr_ptr;
        srch_map   = bitmap;
        if (state == S_ALLOC) begin
            srch_start = wid_after;
            srch_map   = bitmap | (NUM_WARP'(1) << wid_q);
        end
    end

    // First free slot at or after srch_start, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        srch_wid = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NUM_WARP; i++) begin
            idx = int'(srch_start) + i;
            if (idx >= NUM_WARP) begin
                idx = idx - NUM_WARP;
            end
            if (!found && !srch_map[idx]) begin
                found    = 1'b1;
                srch_wid = WID_W'(idx);
            end
        end
    end

    // Block bookkeeping: remaining warps, registered launch id, rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem    <= '0;
            wid_q  <= '0;
            rr_ptr <= '0;
        end else begin
            if (req_fire) begin
                rem <= req_rem;
            end else if (alloc_fire) begin
                rem <= rem - REM_ONE;
            end
            if (load_wid) begin
                wid_q <= srch_wid;
            end
            if (alloc_fire) begin
                rr_ptr <= wid_after;
            end
        end
    end

    // Slot ownership after this cycle's launch and completion.
    always_comb begin
        bitmap_n = bitmap;
        if (alloc_fire) begin
            bitmap_n[wid_q] = 1'b1;
        end
        if (cpl_hit) begin
            bitmap_n[bus.sm_warp_rsp_wid] = 1'b0;
        end
    end

    // Slot bitmap, free counter and unknown-completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap   <= '0;
            free_cnt <= FC_RST;
            err      <= 1'b0;
        end else begin
            bitmap <= bitmap_n;
            unique case ({alloc_fire, cpl_hit})
                2'b10:   free_cnt <= free_cnt - FC_ONE;
                2'b01:   free_cnt <= free_cnt + FC_ONE;
                default: free_cnt <= free_cnt;
            endcase
            err <= cpl_fire & ~cpl_hit;
        end
    end

    // Completion FIFO towards the TPC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.sm_warp_rsp_wid;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sm_warp_alloc.sv
// Bench for sm_warp_alloc: request table, directed corner sequences and a
// random run checked against a slot-ownership / queue reference model.
module tb_sm_warp_alloc;
    localparam int NW    = 8;
    localparam int MAXB  = 4;
    localparam int WW    = 3;
    localparam int CW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW:0]   free_cnt;
    logic          err;

    always #5 clk = ~clk;

    sm_warp_alloc_if #(.NUM_WARP(NW), .MAX_BLK_WARPS(MAXB)) bus ();

    sm_warp_alloc #(
        .NUM_WARP(NW), .WID_W(WW), .MAX_BLK_WARPS(MAXB),
        .CNT_W(CW), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .free_cnt(free_cnt), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // values seen at the negedge before the last active edge
    logic          c_req_fire, c_req_ready;
    logic [CW-1:0] c_req_n;
    logic          c_alloc_fire, c_wvalid, c_last;
    logic [WW-1:0] c_wid;
    logic          c_cpl_fire, c_cpl_ready;
    logic [WW-1:0] c_cpl_wid;
    logic          c_tpc_fire, c_tpc_valid;
    logic [WW-1:0] c_tpc_wid;

    int got_wid[$];
    int got_last[$];
    int got_tick[$];

    // reference model
    bit owned[NW];
    int blk_rem;
    int q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        c_req_ready  = bus.tpc_req_ready;
        c_req_fire   = bus.tpc_req_valid & bus.tpc_req_ready;
        c_req_n      = bus.tpc_req_nwarp;
        c_wvalid     = bus.sm_warp_req_valid;
        c_alloc_fire = bus.sm_warp_req_valid & bus.sm_warp_req_ready;
        c_wid        = bus.sm_warp_req_wid;
        c_last       = bus.sm_warp_req_last;
        c_cpl_ready  = bus.sm_warp_rsp_ready;
        c_cpl_fire   = bus.sm_warp_rsp_valid & bus.sm_warp_rsp_ready;
        c_cpl_wid    = bus.sm_warp_rsp_wid;
        c_tpc_valid  = bus.tpc_rsp_valid;
        c_tpc_fire   = bus.tpc_rsp_valid & bus.tpc_rsp_ready;
        c_tpc_wid    = bus.tpc_rsp_wid;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.tpc_req_valid     = 1'b0;
        bus.tpc_req_nwarp     = '0;
        bus.sm_warp_req_ready = 1'b1;
        bus.sm_warp_rsp_valid = 1'b0;
        bus.sm_warp_rsp_wid   = '0;
        bus.tpc_rsp_ready     = 1'b1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.tpc_req_ready), 1);
        chk({tag, "_rsp_ready"}, 32'(bus.sm_warp_rsp_ready), 1);
        chk({tag, "_tpc_valid"}, 32'(bus.tpc_rsp_valid), 0);
        chk({tag, "_tpc_wid"}, 32'(bus.tpc_rsp_wid), 0);
        chk({tag, "_wvalid"}, 32'(bus.sm_warp_req_valid), 0);
        chk({tag, "_wid"}, 32'(bus.sm_warp_req_wid), 0);
        chk({tag, "_last"}, 32'(bus.sm_warp_req_last), 0);
        chk({tag, "_free_cnt"}, 32'(free_cnt), NW);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset_outs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < NW; i++) owned[i] = 1'b0;
        blk_rem = 0;
        q.delete();
    endtask

    task automatic issue(input int n);
        bit got = 1'b0;
        bus.tpc_req_valid = 1'b1;
        bus.tpc_req_nwarp = CW'(n);
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = c_req_fire;
        end
        bus.tpc_req_valid = 1'b0;
        chk("req_accept", 32'(got), 1);
    endtask

    task automatic collect(input int ticks);
        got_wid.delete();
        got_last.delete();
        got_tick.delete();
        for (int i = 0; i < ticks; i++) begin
            tick();
            if (c_alloc_fire) begin
                got_wid.push_back(int'(c_wid));
                got_last.push_back(int'(c_last));
                got_tick.push_back(i);
            end
        end
    endtask

    task automatic complete(input int w);
        bit got = 1'b0;
        bus.sm_warp_rsp_valid = 1'b1;
        bus.sm_warp_rsp_wid   = WW'(w);
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            got = c_cpl_fire;
        end
        bus.sm_warp_rsp_valid = 1'b0;
        chk("cpl_accept", 32'(got), 1);
    endtask

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < NW; i++) if (!owned[i]) n++;
        return n;
    endfunction

    // One random cycle: drive, observe, advance the reference model.
    task automatic rnd_cycle(input bit allow_new);
        int  w;
        int  cand[$];
        bit  rel, err_new;
        if (allow_new && !bus.tpc_req_valid && $urandom_range(0, 3) == 0) begin
            bus.tpc_req_valid = 1'b1;
            bus.tpc_req_nwarp = CW'($urandom_range(0, 7));
        end
        if (allow_new) begin
            bus.sm_warp_req_ready = 1'($urandom_range(0, 1));
            bus.tpc_rsp_ready     = ($urandom_range(0, 2) != 0);
        end else begin
            bus.sm_warp_req_ready = 1'b1;
            bus.tpc_rsp_ready     = 1'b1;
        end
        if (!bus.sm_warp_rsp_valid && $urandom_range(0, 2) == 0) begin
            for (int i = 0; i < NW; i++) if (owned[i]) cand.push_back(i);
            if (cand.size() > 0 && (!allow_new || $urandom_range(0, 9) != 0))
                w = cand[$urandom_range(0, cand.size() - 1)];
            else
                w = $urandom_range(0, NW - 1);
            bus.sm_warp_rsp_valid = 1'b1;
            bus.sm_warp_rsp_wid   = WW'(w);
        end
        tick();
        chk("rnd_req_ready", 32'(c_req_ready), 32'(blk_rem == 0));
        chk("rnd_wvalid_idle", 32'(c_wvalid && blk_rem == 0), 0);
        chk("rnd_cpl_ready", 32'(c_cpl_ready), 32'(q.size() < DEPTH));
        chk("rnd_tpc_valid", 32'(c_tpc_valid), 32'(q.size() > 0));
        if (c_tpc_valid && q.size() > 0)
            chk("rnd_tpc_wid", 32'(c_tpc_wid), q[0]);
        if (c_tpc_fire && q.size() > 0) void'(q.pop_front());
        rel = 1'b0;
        err_new = 1'b0;
        if (c_cpl_fire) begin
            if (owned[c_cpl_wid]) rel = 1'b1;
            else err_new = 1'b1;
        end
        if (c_alloc_fire) begin
            chk("rnd_alloc_free", 32'(owned[c_wid]), 0);
            chk("rnd_last", 32'(c_last), 32'(blk_rem == 1));
        end
        if (rel) begin
            owned[c_cpl_wid] = 1'b0;
            q.push_back(int'(c_cpl_wid));
        end
        if (c_alloc_fire) begin
            owned[c_wid] = 1'b1;
            if (blk_rem > 0) blk_rem--;
        end
        if (c_req_fire) begin
            blk_rem = (int'(c_req_n) > MAXB) ? MAXB : int'(c_req_n);
            bus.tpc_req_valid = 1'b0;
        end
        if (c_cpl_fire) bus.sm_warp_rsp_valid = 1'b0;
        chk("rnd_free_cnt", 32'(free_cnt), n_free());
        chk("rnd_err", 32'(err), 32'(err_new));
    endtask

    typedef struct {
        int nwarp;
        int exp_cnt;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int   ord[4];
        int   held;
        bit   seen;
        bit   done;

        tbl[0] = '{0, 0};
        tbl[1] = '{1, 1};
        tbl[2] = '{3, 3};
        tbl[3] = '{4, 4};
        tbl[4] = '{5, 4};
        tbl[5] = '{7, 4};

        // single blocks from a fresh reset
        for (int t = 0; t < 6; t++) begin
            do_reset();
            issue(tbl[t].nwarp);
            collect(12);
            chk("tbl_count", got_wid.size(), tbl[t].exp_cnt);
            if (got_tick.size() > 0) chk("tbl_latency", got_tick[0], 1);
            for (int k = 0; k < got_wid.size() && k < tbl[t].exp_cnt; k++) begin
                chk("tbl_wid", got_wid[k], k);
                chk("tbl_last", got_last[k], 32'(k == tbl[t].exp_cnt - 1));
                chk("tbl_consec", got_tick[k], got_tick[0] + k);
            end
            chk("tbl_free_cnt", 32'(free_cnt), NW - tbl[t].exp_cnt);
            chk("tbl_idle", 32'(bus.tpc_req_ready), 1);
        end

        // full SM: block waits until two slots are freed
        do_reset();
        issue(4);
        collect(8);
        issue(4);
        collect(8);
        if (got_wid.size() > 0) chk("full_second_first", got_wid[0], 4);
        chk("full_free0", 32'(free_cnt), 0);
        issue(2);
        collect(5);
        chk("wait_no_issue", got_wid.size(), 0);
        chk("wait_req_ready", 32'(c_req_ready), 0);
        complete(5);
        complete(6);
        collect(6);
        chk("wait_count", got_wid.size(), 2);
        if (got_wid.size() == 2) begin
            chk("wait_wid0", got_wid[0], 5);
            chk("wait_wid1", got_wid[1], 6);
            chk("wait_last0", got_last[0], 0);
            chk("wait_last1", got_last[1], 1);
        end
        chk("wait_free", 32'(free_cnt), 0);

        // launcher stall holds valid and wid
        do_reset();
        bus.sm_warp_req_ready = 1'b0;
        issue(2);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            seen = c_wvalid;
        end
        chk("stall_valid_rise", 32'(seen), 1);
        held = int'(c_wid);
        chk("stall_wid", held, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_valid", 32'(c_wvalid), 1);
            chk("stall_hold_wid", 32'(c_wid), held);
        end
        bus.sm_warp_req_ready = 1'b1;
        tick();
        chk("stall_fire", 32'(c_alloc_fire), 1);
        chk("stall_fire_wid", 32'(c_wid), held);
        bus.sm_warp_req_ready = 1'b0;
        tick();
        chk("stall_one_bit", 32'(free_cnt), NW - 1);
        chk("stall_next_wid", 32'(c_wid), 1);
        bus.sm_warp_req_ready = 1'b1;
        collect(4);
        chk("stall_rest", got_wid.size(), 1);
        chk("stall_free", 32'(free_cnt), NW - 2);

        // completion FIFO fills, back-pressures, drains in order
        do_reset();
        issue(4);
        collect(8);
        issue(1);
        collect(6);
        chk("fifo_pre_free", 32'(free_cnt), NW - 5);
        bus.tpc_rsp_ready = 1'b0;
        ord = '{3, 1, 4, 0};
        for (int i = 0; i < 4; i++) complete(ord[i]);
        bus.sm_warp_rsp_valid = 1'b1;
        bus.sm_warp_rsp_wid   = WW'(2);
        tick();
        chk("fifo_full_ready", 32'(c_cpl_ready), 0);
        chk("fifo_full_nofire", 32'(c_cpl_fire), 0);
        tick();
        chk("fifo_full_ready2", 32'(c_cpl_ready), 0);
        bus.sm_warp_rsp_valid = 1'b0;
        bus.tpc_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fifo_pop", 32'(c_tpc_fire), 1);
            chk("fifo_order", 32'(c_tpc_wid), ord[i]);
        end
        tick();
        chk("fifo_empty", 32'(c_tpc_valid), 0);
        chk("fifo_free", 32'(free_cnt), NW - 1);
        complete(2);
        tick();
        chk("fifo_last_free", 32'(free_cnt), NW);

        // completion of an unassigned wid
        do_reset();
        bus.sm_warp_rsp_valid = 1'b1;
        bus.sm_warp_rsp_wid   = WW'(7);
        tick();
        bus.sm_warp_rsp_valid = 1'b0;
        chk("unk_consumed", 32'(c_cpl_fire), 1);
        chk("unk_err_pulse", 32'(err), 1);
        tick();
        chk("unk_err_clear", 32'(err), 0);
        chk("unk_no_rsp", 32'(c_tpc_valid), 0);
        chk("unk_no_rsp2", 32'(bus.tpc_rsp_valid), 0);
        chk("unk_free", 32'(free_cnt), NW);

        // reset mid-allocation
        do_reset();
        issue(4);
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            seen = c_alloc_fire;
        end
        chk("midrst_first", 32'(seen), 1);
        bus.sm_warp_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        @(posedge clk);
        #1;
        bus.sm_warp_req_ready = 1'b1;
        rst_n = 1'b1;
        collect(6);
        chk("midrst_no_reissue", got_wid.size(), 0);
        chk("midrst_free", 32'(free_cnt), NW);

        // random traffic against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            rnd_cycle(1'b0);
            done = (blk_rem == 0) && !bus.tpc_req_valid && (q.size() == 0);
        end
        chk("rnd_drain", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
